// File: rtl/tx_pipe_pkg.sv
// rtl/tx_pipe_pkg.sv - shared types and helpers for the buffered UART transmit pipe
package tx_pipe_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_EVEN = 2'd1,
        PAR_ODD  = 2'd2
    } parity_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_t;

    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_tx_frame.sv
// rtl/uart_tx_frame.sv - UART frame serializer with ready/valid word input
module uart_tx_frame import tx_pipe_pkg::*; #(
    parameter int      CLK_FREQ  = 12_000_000,
    parameter int      BAUD      = 9_600,
    parameter int      DATA_BITS = 8,
    parameter parity_t PARITY    = PAR_NONE,
    parameter int      STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 valid,
    input  logic [DATA_BITS-1:0] data,
    output logic                 ready,
    output logic                 busy,
    output logic                 tx
);

    localparam int CPB = clks_per_bit(CLK_FREQ, BAUD);
    localparam int CW  = $clog2(CPB);
    localparam logic [CW-1:0] CNT_MAX = CW'(CPB - 1);

    tx_state_t            state;
    logic [CW-1:0]        cnt;
    logic [3:0]           bit_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bit;
    logic                 tx_nxt;
    logic                 cnt_last;
    logic                 data_last;
    logic                 stop_last;

    assign cnt_last  = (cnt == CNT_MAX);
    assign data_last = (bit_idx == 4'(DATA_BITS - 1));
    assign stop_last = (bit_idx == 4'(STOP_BITS - 1));
    assign busy      = (state != ST_IDLE);

    // Loading on the last STOP cycle is what makes consecutive frames gapless.
    assign ready = valid && ((state == ST_IDLE) ||
                             (state == ST_STOP && cnt_last && stop_last));

    always_comb begin
        tx_nxt = 1'b1;
        case (state)
            ST_START:  tx_nxt = 1'b0;
            ST_DATA:   tx_nxt = shreg[0];
            ST_PARITY: tx_nxt = par_bit;
            default:   tx_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            par_bit <= 1'b0;
            tx      <= 1'b1;
        end else begin
            tx <= tx_nxt;
            if (ready) begin
                shreg   <= data;
                par_bit <= (^data) ^ (PARITY == PAR_ODD);
                cnt     <= '0;
                bit_idx <= '0;
                state   <= ST_START;
            end else if (state != ST_IDLE) begin
                if (!cnt_last) begin
                    cnt <= cnt + 1'b1;
                end else begin
                    cnt <= '0;
                    case (state)
                        ST_START: begin
                            bit_idx <= '0;
                            state   <= ST_DATA;
                        end
                        ST_DATA: begin
                            shreg <= shreg >> 1;
                            if (data_last) begin
                                bit_idx <= '0;
                                state   <= (PARITY == PAR_NONE) ? ST_STOP : ST_PARITY;
                            end else begin
                                bit_idx <= bit_idx + 4'd1;
                            end
                        end
                        ST_PARITY: begin
                            bit_idx <= '0;
                            state   <= ST_STOP;
                        end
                        ST_STOP: begin
                            if (stop_last) begin
                                bit_idx <= '0;
                                state   <= ST_IDLE;
                            end else begin
                                bit_idx <= bit_idx + 4'd1;
                            end
                        end
                        default: state <= ST_IDLE;
                    endcase
                end
            end
        end
    end

endmodule

// File: rtl/tx_pipe_cfg.sv
// rtl/tx_pipe_cfg.sv - parametrised FIFO-buffered UART transmit pipe
module tx_pipe_cfg import tx_pipe_pkg::*; #(
    parameter int      CLK_FREQ  = 12_000_000,
    parameter int      BAUD      = 9_600,
    parameter int      DATA_BITS = 8,
    parameter int      DEPTH     = 16,
    parameter parity_t PARITY    = PAR_NONE,
    parameter int      STOP_BITS = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_back,
    input  logic [DATA_BITS-1:0]     data_in,
    input  logic                     flush,
    input  logic                     clr_error,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     busy,
    output logic                     tx,
    output logic                     error
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_BITS-1:0] mem [DEPTH];
    logic [AW:0]          wptr;
    logic [AW:0]          rptr;
    logic [AW:0]          wptr_nxt;
    logic [AW:0]          rptr_nxt;
    logic                 push_ok;
    logic                 overflow;
    logic                 pop;

    // A push coinciding with flush is simply discarded, never an overflow.
    assign push_ok  = push_back && !full && !flush;
    assign overflow = push_back &&  full && !flush;

    always_comb begin
        wptr_nxt = wptr;
        rptr_nxt = rptr;
        if (flush) begin
            wptr_nxt = '0;
            rptr_nxt = '0;
        end else begin
            if (push_ok) wptr_nxt = wptr + 1'b1;
            if (pop)     rptr_nxt = rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wptr  <= '0;
            rptr  <= '0;
            full  <= 1'b0;
            empty <= 1'b1;
            level <= '0;
            error <= 1'b0;
        end else begin
            wptr  <= wptr_nxt;
            rptr  <= rptr_nxt;
            full  <= (wptr_nxt[AW] != rptr_nxt[AW]) &&
                     (wptr_nxt[AW-1:0] == rptr_nxt[AW-1:0]);
            empty <= (wptr_nxt == rptr_nxt);
            level <= wptr_nxt - rptr_nxt;
            if (overflow)       error <= 1'b1;
            else if (clr_error) error <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wptr[AW-1:0]] <= data_in;
    end

    uart_tx_frame #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD      (BAUD),
        .DATA_BITS (DATA_BITS),
        .PARITY    (PARITY),
        .STOP_BITS (STOP_BITS)
    ) u_frame (
        .clk   (clk),
        .rst   (rst),
        .valid (!empty),
        .data  (mem[rptr[AW-1:0]]),
        .ready (pop),
        .busy  (busy),
        .tx    (tx)
    );

endmodule

// File: tb/tb_tx_pipe_cfg.sv
// tb/tb_tx_pipe_cfg.sv - directed self-checking bench for tx_pipe_cfg
module tb_tx_pipe_cfg;
    import tx_pipe_pkg::*;

    logic clk;
    logic rst;

    logic       a_push, a_flush, a_clr, a_full, a_empty, a_busy, a_tx, a_error;
    logic [7:0] a_data;
    logic [4:0] a_level;

    logic       b_push, b_full, b_empty, b_busy, b_tx, b_error;
    logic [6:0] b_data;
    logic [4:0] b_level;

    logic       c_push, c_full, c_empty, c_busy, c_tx, c_error;
    logic [7:0] c_data;
    logic [4:0] c_level;

    logic       d_push, d_clr, d_full, d_empty, d_busy, d_tx, d_error;
    logic [7:0] d_data;
    logic [2:0] d_level;

    logic txs   [4];
    logic busys [4];

    int checks   = 0;
    int failures = 0;

    tx_pipe_cfg #(.CLK_FREQ(1000), .BAUD(100), .DATA_BITS(8), .DEPTH(16),
                  .PARITY(PAR_NONE), .STOP_BITS(1)) u_a (
        .clk(clk), .rst(rst), .push_back(a_push), .data_in(a_data), .flush(a_flush),
        .clr_error(a_clr), .full(a_full), .empty(a_empty), .level(a_level),
        .busy(a_busy), .tx(a_tx), .error(a_error));

    tx_pipe_cfg #(.CLK_FREQ(1000), .BAUD(100), .DATA_BITS(7), .DEPTH(16),
                  .PARITY(PAR_EVEN), .STOP_BITS(1)) u_b (
        .clk(clk), .rst(rst), .push_back(b_push), .data_in(b_data), .flush(1'b0),
        .clr_error(1'b0), .full(b_full), .empty(b_empty), .level(b_level),
        .busy(b_busy), .tx(b_tx), .error(b_error));

    tx_pipe_cfg #(.CLK_FREQ(1000), .BAUD(100), .DATA_BITS(8), .DEPTH(16),
                  .PARITY(PAR_ODD), .STOP_BITS(2)) u_c (
        .clk(clk), .rst(rst), .push_back(c_push), .data_in(c_data), .flush(1'b0),
        .clr_error(1'b0), .full(c_full), .empty(c_empty), .level(c_level),
        .busy(c_busy), .tx(c_tx), .error(c_error));

    tx_pipe_cfg #(.CLK_FREQ(1000), .BAUD(100), .DATA_BITS(8), .DEPTH(4),
                  .PARITY(PAR_NONE), .STOP_BITS(1)) u_d (
        .clk(clk), .rst(rst), .push_back(d_push), .data_in(d_data), .flush(1'b0),
        .clr_error(d_clr), .full(d_full), .empty(d_empty), .level(d_level),
        .busy(d_busy), .tx(d_tx), .error(d_error));

    assign txs[0] = a_tx;   assign busys[0] = a_busy;
    assign txs[1] = b_tx;   assign busys[1] = b_busy;
    assign txs[2] = c_tx;   assign busys[2] = c_busy;
    assign txs[3] = d_tx;   assign busys[3] = d_busy;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Samples every bit mid-bit; caller is 'lead' ticks before the first sample.
    task automatic sample_frame(input int inst, input logic [15:0] exp, input int nbits,
                                input int lead, input bit more, input string tag);
        repeat (lead) tick();
        for (int i = 0; i < nbits; i++) begin
            if (i > 0) repeat (10) tick();
            check($sformatf("%s_bit%0d", tag, i), txs[inst], exp[i]);
        end
        repeat (3) tick();
        check({tag, "_busy_tail"}, busys[inst], 1);
        tick();
        check({tag, "_busy_end"}, busys[inst], more);
        check({tag, "_last_stop"}, txs[inst], 1);
        tick();
        check({tag, "_after"}, txs[inst], more ? 0 : 1);
    endtask

    int exp_lvl [6] = '{1, 1, 2, 3, 4, 4};

    initial begin
        rst = 1'b0;
        a_push = 0; a_flush = 0; a_clr = 0; a_data = '0;
        b_push = 0; b_data = '0;
        c_push = 0; c_data = '0;
        d_push = 0; d_clr = 0; d_data = '0;
        repeat (3) tick();
        check("rst_tx", a_tx, 1);
        check("rst_busy", a_busy, 0);
        check("rst_empty", a_empty, 1);
        check("rst_full", a_full, 0);
        check("rst_level", a_level, 0);
        check("rst_error", a_error, 0);
        check("rst_d_tx", d_tx, 1);
        rst = 1'b1;
        tick();

        // single 8N1 frame of 0xA5
        a_push = 1; a_data = 8'hA5;
        tick();
        a_push = 0;
        check("basic_empty", a_empty, 0);
        check("basic_level1", a_level, 1);
        tick();
        check("basic_pop_level", a_level, 0);
        check("basic_busy", a_busy, 1);
        check("basic_tx_hold", a_tx, 1);
        tick();
        check("basic_tx_fall", a_tx, 0);
        sample_frame(0, 16'b1101001010, 10, 5, 0, "basic");

        // 7E1 frame of 0x03
        b_push = 1; b_data = 7'h03;
        tick();
        b_push = 0;
        tick();
        tick();
        sample_frame(1, 16'b1000000110, 10, 5, 0, "even7");

        // 8O2 frame of 0x03
        c_push = 1; c_data = 8'h03;
        tick();
        c_push = 0;
        tick();
        tick();
        sample_frame(2, 16'b111000000110, 12, 5, 0, "odd2");

        // back-to-back: 0x55 and 0x0F queued behind 0xFF
        a_push = 1; a_data = 8'hFF;
        tick();
        a_push = 0;
        tick();
        a_push = 1; a_data = 8'h55;
        tick();
        check("b2b_level1", a_level, 1);
        a_data = 8'h0F;
        tick();
        a_push = 0;
        check("b2b_level2", a_level, 2);
        sample_frame(0, 16'b1111111110, 10, 4, 1, "b2b_ff");
        check("b2b_level_after1", a_level, 1);
        sample_frame(0, 16'b1010101010, 10, 5, 1, "b2b_55");
        check("b2b_level_after2", a_level, 0);
        sample_frame(0, 16'b1000011110, 10, 5, 0, "b2b_0f");
        check("b2b_no_error", a_error, 0);

        // overflow on the 4-deep instance; 6th push also carries clr_error
        for (int i = 0; i < 6; i++) begin
            d_push = 1; d_data = 8'(8'h11 * (i + 1)); d_clr = (i == 5);
            tick();
            check($sformatf("ovf_level%0d", i), d_level, exp_lvl[i]);
        end
        d_push = 0; d_clr = 0;
        check("ovf_full", d_full, 1);
        check("ovf_error_set_wins", d_error, 1);
        for (int k = 0; k < 5; k++) begin
            sample_frame(3, {1'b1, 8'(8'h11 * (k + 1)), 1'b0}, 10, (k == 0) ? 2 : 5,
                         k < 4, $sformatf("ovf_f%0d", k));
        end
        repeat (100) tick();
        check("ovf_no_6th_busy", d_busy, 0);
        check("ovf_no_6th_tx", d_tx, 1);
        check("ovf_error_sticky", d_error, 1);
        d_clr = 1;
        tick();
        d_clr = 0;
        check("ovf_error_clr", d_error, 0);

        // flush during the second frame with three words queued
        for (int i = 0; i < 5; i++) begin
            a_push = 1; a_data = 8'(8'h81 + i);
            tick();
        end
        a_push = 0;
        check("fl_level4", a_level, 4);
        sample_frame(0, {1'b1, 8'h81, 1'b0}, 10, 3, 1, "fl_f1");
        check("fl_level3", a_level, 3);
        a_flush = 1; a_push = 1; a_data = 8'hEE;
        tick();
        a_flush = 0; a_push = 0;
        check("fl_level0", a_level, 0);
        check("fl_empty", a_empty, 1);
        check("fl_no_error", a_error, 0);
        sample_frame(0, {1'b1, 8'h82, 1'b0}, 10, 4, 0, "fl_f2");
        repeat (50) tick();
        check("fl_idle_busy", a_busy, 0);
        check("fl_idle_tx", a_tx, 1);
        check("fl_idle_level", a_level, 0);

        // reset in the middle of a frame with one word still queued
        a_push = 1; a_data = 8'h00;
        tick();
        tick();
        a_push = 0;
        repeat (28) tick();
        check("mid_tx_low", a_tx, 0);
        check("mid_level", a_level, 1);
        rst = 1'b0;
        tick();
        check("mid_rst_tx", a_tx, 1);
        check("mid_rst_busy", a_busy, 0);
        check("mid_rst_empty", a_empty, 1);
        check("mid_rst_level", a_level, 0);
        rst = 1'b1;
        repeat (30) tick();
        check("post_rst_tx", a_tx, 1);
        check("post_rst_busy", a_busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tx_pipe_cfg.md
Name: tx_pipe_cfg

Overview:
- Parametrised successor of the UART transmit pipe: a DEPTH-entry FIFO feeding an integrated serializer.
- Configurable data width, parity and stop bits.
- Adds back-to-back frames with zero gap, a fill-level output, flush, and a clearable sticky overflow flag.
- Sits between a byte-producing core (e.g. ULM putc path) and the board TX pin.

Parameters:
- CLK_FREQ, 12_000_000, system clock in Hz.
- BAUD, 9_600, line rate. CLKS_PER_BIT = CLK_FREQ/BAUD (integer division, must be ≥2).
- DATA_BITS, 8, payload bits per frame, legal 5..9.
- DEPTH, 16, FIFO entries, power of two ≥2.
- PARITY, PAR_NONE, parity_t: PAR_NONE / PAR_EVEN / PAR_ODD.
- STOP_BITS, 1, legal 1 or 2.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-low reset (asserted when 0).
- push_back  in  1  write strobe for data_in.
- data_in  in  DATA_BITS  word to enqueue.
- flush  in  1  discard all queued words.
- clr_error  in  1  clear sticky error.
- full  out  1  FIFO holds DEPTH words.
- empty  out  1  FIFO holds 0 words.
- level  out  $clog2(DEPTH)+1  words queued, excluding the word in flight.
- busy  out  1  serializer is transmitting a frame.
- tx  out  1  serial line, idle high.
- error  out  1  sticky overflow flag.

Behaviour:
- **Reset (rst==0 at a posedge):**
  - tx=1, busy=0, empty=1, full=0, level=0, error=0.
  - FIFO pointers cleared; serializer to IDLE.
  - Reset mid-frame aborts the frame: tx=1 from the next cycle.
- **Push:**
  - Accepted when push_back=1 and full=0. Data is written at that edge and level increments.
  - full, empty and level are registered. A push while full=1 is dropped and sets error=1, even if a pop occurs in the same cycle.
- **Simultaneous push and pop** when neither full nor empty: level unchanged, both operations happen.
- **flush=1:**
  - Pointers reset and level=0 at that edge.
  - A push in the same cycle is discarded without setting error.
  - The frame in flight completes normally.
- **error:**
  - Stays 1 until clr_error=1 or reset.
  - Overflow and clr_error in the same cycle: set wins.
- **Serializer FSM:** IDLE, START, DATA, PARITY, STOP.
  - IDLE: tx=1. If FIFO is non-empty, pop the head into the shift register and go to START.
  - START: tx=0 for CLKS_PER_BIT cycles.
  - DATA: LSB first, DATA_BITS bits, each lasting CLKS_PER_BIT cycles.
  - PARITY: entered only if PARITY≠PAR_NONE.
    - tx = XOR of data for PAR_EVEN.
    - tx = inverted XOR of data for PAR_ODD.
  - STOP: tx=1 for STOP_BITS×CLKS_PER_BIT cycles.
  - On the last cycle of STOP: if FIFO is non-empty, pop and go directly to START, so there is no idle cycle between frames. Otherwise go to IDLE.
- **busy** =1 in every state except IDLE.
- **Latency:** push at edge N into an empty FIFO with the serializer IDLE gives:
  - empty=0 after edge N;
  - pop at edge N+1;
  - tx falls at edge N+2.
- **Bit counter and timing:**
  - Bit counter is $clog2(CLKS_PER_BIT) bits and wraps at CLKS_PER_BIT-1.
  - Frame length is exactly (1+DATA_BITS+(PARITY≠NONE)+STOP_BITS)×CLKS_PER_BIT cycles.
- **Storage:** internal FIFO uses $clog2(DEPTH)+1-bit read/write pointers. full/empty are derived from MSB-differing/equal pointers; wrap-around is natural.

Decomposition:
- tx_pipe_pkg:
  - parity_t enum (PAR_NONE, PAR_EVEN, PAR_ODD);
  - tx_state_t enum for the FSM states;
  - clks_per_bit() helper function.
- One sub-module, uart_tx_frame:
  - the serializer FSM with a ready/valid input (valid = !empty, ready = pop);
  - parametrised by CLK_FREQ, BAUD, DATA_BITS, PARITY, STOP_BITS.
- The FIFO stays inline in tx_pipe_cfg.

Test Plan:
- **Single frame, basic:** CLK_FREQ=1000, BAUD=100, DATA_BITS=8, no parity, 1 stop; push 0xA5.
  - tx falls 2 cycles after the push.
  - Bits sampled mid-bit: 0,1,0,1,0,0,1,0,1,1, each 10 cycles.
  - busy=0 after 100 cycles.
- **Even parity and 7-bit frame:** PARITY=PAR_EVEN, DATA_BITS=7; push 0x03.
  - Parity bit = 0.
  - Frame is 10 bits (100 cycles).
- **Odd parity and 2 stop bits:** PARITY=PAR_ODD, STOP_BITS=2; push 0x03.
  - Parity bit = 1.
  - Stop high for 20 cycles.
- **Back-to-back:** push 0x55, 0x0F on consecutive cycles.
  - Second start bit begins on the cycle immediately after the first stop bit ends.
  - level goes 1 → 2 → 1 → 0.
- **Overflow:** DEPTH=4; push 6 words quickly while the first is in flight.
  - full=1, level=4.
  - 6th push dropped, error=1.
  - Exactly 5 frames transmitted.
  - clr_error → error=0.
- **Flush and reset mid-frame:**
  - Flush during the 2nd frame with 3 queued: 2nd frame completes, no further frames, level=0.
  - Later, rst=0 mid-frame: tx=1 and busy=0 the next cycle.
